accel_ball_integrator: RTL and testbench

//  Parametrised successor to the single-ball accelerometer mover.

---
 rtl/accel_ball_integrator_if.sv | 29 ++
 rtl/accel_ball_integrator.sv | 218 +++++++++++++++++++++
 tb/tb_accel_ball_integrator.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_ball_integrator_if.sv
// Tilt samples in, ball state out: the link between AccelerometerCtl,
// the ball integrator and the display/game logic.
interface accel_ball_integrator_if #(
    parameter int unsigned ACCEL_W = 8,
    parameter int unsigned POS_W   = 10,
    parameter int unsigned VEL_W   = 12
);
    logic signed [ACCEL_W-1:0] accel_x_in;
    logic signed [ACCEL_W-1:0] accel_y_in;
    logic                      accel_valid;
    logic                      hold;
    logic                      recenter;
    logic [POS_W-1:0]          pos_x_out;
    logic [POS_W-1:0]          pos_y_out;
    logic signed [VEL_W-1:0]   vel_x_out;
    logic signed [VEL_W-1:0]   vel_y_out;
    logic [3:0]                wall_hit;
    logic                      update_done;

    modport master (
        output accel_x_in, accel_y_in, accel_valid, hold, recenter,
        input  pos_x_out, pos_y_out, vel_x_out, vel_y_out, wall_hit, update_done
    );

    modport slave (
        input  accel_x_in, accel_y_in, accel_valid, hold, recenter,
        output pos_x_out, pos_y_out, vel_x_out, vel_y_out, wall_hit, update_done
    );
endinterface

// File: rtl/accel_ball_integrator.sv
// Fixed-point ball physics driven by accelerometer tilt: dead-zone, friction, wall clamp.
// Define BALL_BOUNCE_EN to reflect velocity at 75% on a wall hit instead of stopping.
module accel_ball_integrator #(
    parameter int unsigned ACCEL_W        = 8,
    parameter int unsigned POS_W          = 10,
    parameter int unsigned FRAC_W         = 4,
    parameter int unsigned VEL_W          = 12,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned DEADZONE       = 4,
    parameter int unsigned FRICTION_SHIFT = 4,
    parameter int unsigned TICK_DIV       = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    accel_ball_integrator_if.slave   bus
);

    localparam int unsigned P_W   = POS_W + FRAC_W + 1;
    localparam int unsigned SUM_W = VEL_W + 2;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [SUM_W-1:0] V_HI  = SUM_W'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] V_LO  = -V_HI - SUM_W'(1);
    localparam logic signed [P_W-1:0]   X_LIM = P_W'(X_MAX << FRAC_W);
    localparam logic signed [P_W-1:0]   Y_LIM = P_W'(Y_MAX << FRAC_W);
    localparam logic signed [P_W-1:0]   X_CEN = P_W'((X_MAX / 2) << FRAC_W);
    localparam logic signed [P_W-1:0]   Y_CEN = P_W'((Y_MAX / 2) << FRAC_W);
    localparam logic [POS_W-1:0]        X_CEN_INT = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0]        Y_CEN_INT = POS_W'(Y_MAX / 2);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        VEL,
        POS,
        WALL
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick_c;
    logic signed [ACCEL_W-1:0] lat_x;
    logic signed [ACCEL_W-1:0] lat_y;
    logic signed [VEL_W-1:0]   acc_x;
    logic signed [VEL_W-1:0]   acc_y;
    logic signed [VEL_W-1:0]   vel_x;
    logic signed [VEL_W-1:0]   vel_y;
    logic signed [P_W-1:0]     p_x;
    logic signed [P_W-1:0]     p_y;
    logic [POS_W-1:0]          pos_x_q;
    logic [POS_W-1:0]          pos_y_q;
    logic [3:0]                wall_hit_q;
    logic                      update_done_q;

    logic                      hit_l_c;
    logic                      hit_r_c;
    logic                      hit_t_c;
    logic                      hit_b_c;
    logic signed [P_W-1:0]     px_clamp_c;
    logic signed [P_W-1:0]     py_clamp_c;

    // Small tilts are noise: treat |a| <= DEADZONE as level.
    function automatic logic signed [VEL_W-1:0] dead_zone(input logic signed [ACCEL_W-1:0] a);
        int mag;
        mag = a[ACCEL_W-1] ? -int'(a) : int'(a);
        return (mag <= int'(DEADZONE)) ? '0 : VEL_W'(a);
    endfunction

    // One velocity step with proportional friction, saturated to the signed range.
    function automatic logic signed [VEL_W-1:0] vel_step(input logic signed [VEL_W-1:0] v,
                                                         input logic signed [VEL_W-1:0] a);
        logic signed [SUM_W-1:0] sum;
        sum = SUM_W'(v) + SUM_W'(a) - SUM_W'(v >>> FRICTION_SHIFT);
        if (sum > V_HI) begin
            sum = V_HI;
        end else if (sum < V_LO) begin
            sum = V_LO;
        end
        return VEL_W'(sum);
    endfunction

`ifdef BALL_BOUNCE_EN
    localparam logic signed [VEL_W-1:0] V_REST = VEL_W'(2 ** FRAC_W);

    // 75% reflection; anything slower than one pixel per update comes to rest on the wall.
    function automatic logic signed [VEL_W-1:0] wall_vel(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W-1:0] r;
        r = (v >>> 2) - v;
        return ((r < V_REST) && (r > -V_REST)) ? '0 : r;
    endfunction
`endif

    assign tick_c = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Free-running physics tick; never paused by hold or recenter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_x <= '0;
            lat_y <= '0;
        end else if (bus.accel_valid) begin
            lat_x <= bus.accel_x_in;
            lat_y <= bus.accel_y_in;
        end
    end

    // Wall detection and clamp on the freshly integrated position.
    always_comb begin
        hit_l_c    = p_x[P_W-1];
        hit_r_c    = (p_x > X_LIM);
        hit_t_c    = p_y[P_W-1];
        hit_b_c    = (p_y > Y_LIM);
        px_clamp_c = p_x;
        py_clamp_c = p_y;
        if (hit_l_c) begin
            px_clamp_c = '0;
        end else if (hit_r_c) begin
            px_clamp_c = X_LIM;
        end
        if (hit_t_c) begin
            py_clamp_c = '0;
        end else if (hit_b_c) begin
            py_clamp_c = Y_LIM;
        end
    end

    // Update sequencer: SAMPLE -> VEL -> POS -> WALL, recenter overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc_x         <= '0;
            acc_y         <= '0;
            vel_x         <= '0;
            vel_y         <= '0;
            p_x           <= X_CEN;
            p_y           <= Y_CEN;
            pos_x_q       <= X_CEN_INT;
            pos_y_q       <= Y_CEN_INT;
            wall_hit_q    <= '0;
            update_done_q <= 1'b0;
        end else begin
            update_done_q <= 1'b0;
            if (bus.recenter) begin
                state   <= IDLE;
                vel_x   <= '0;
                vel_y   <= '0;
                p_x     <= X_CEN;
                p_y     <= Y_CEN;
                pos_x_q <= X_CEN_INT;
                pos_y_q <= Y_CEN_INT;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tick_c && !bus.hold) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        acc_x <= dead_zone(lat_x);
                        acc_y <= dead_zone(lat_y);
                        state <= VEL;
                    end
                    VEL: begin
                        vel_x <= vel_step(vel_x, acc_x);
                        vel_y <= vel_step(vel_y, acc_y);
                        state <= POS;
                    end
                    POS: begin
                        p_x   <= p_x + P_W'(vel_x);
                        p_y   <= p_y + P_W'(vel_y);
                        state <= WALL;
                    end
                    WALL: begin
                        p_x           <= px_clamp_c;
                        p_y           <= py_clamp_c;
                        pos_x_q       <= px_clamp_c[FRAC_W +: POS_W];
                        pos_y_q       <= py_clamp_c[FRAC_W +: POS_W];
                        wall_hit_q    <= {hit_t_c, hit_b_c, hit_r_c, hit_l_c};
                        update_done_q <= 1'b1;
                        state         <= IDLE;
`ifdef BALL_BOUNCE_EN
                        if (hit_l_c || hit_r_c) begin
                            vel_x <= wall_vel(vel_x);
                        end
                        if (hit_t_c || hit_b_c) begin
                            vel_y <= wall_vel(vel_y);
                        end
`else
                        if (hit_l_c || hit_r_c) begin
                            vel_x <= '0;
                        end
                        if (hit_t_c || hit_b_c) begin
                            vel_y <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pos_x_out   = pos_x_q;
    assign bus.pos_y_out   = pos_y_q;
    assign bus.vel_x_out   = vel_x;
    assign bus.vel_y_out   = vel_y;
    assign bus.wall_hit    = wall_hit_q;
    assign bus.update_done = update_done_q;

endmodule

// File: tb/tb_accel_ball_integrator.sv
// Bench for accel_ball_integrator: per-update physics model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_accel_ball_integrator;
    localparam int TICK  = 16;
    localparam int XC    = 319;
    localparam int YC    = 239;
    localparam int X_LIM = 639 * 16;
    localparam int Y_LIM = 479 * 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    accel_ball_integrator_if bus ();

    accel_ball_integrator #(.TICK_DIV(TICK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt, m_age, m_lx, m_ly, m_vx, m_vy, m_px, m_py, m_wall;
    int r_vx_mid, r_vy_mid, r_vx, r_vy, r_px, r_py, r_wall;
    int xl, xh, yl, yh;
    bit m_busy, m_done;

    function automatic int dz(input int a);
        return (((a < 0) ? -a : a) <= 4) ? 0 : a;
    endfunction

    function automatic int sat(input int v);
        return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    endfunction

    // Whole update for one axis in 1/16-pixel units.
    function automatic void axis(input int a_raw, input int v, input int p, input int lim,
                                 output int v_mid, output int p_new, output int v_new,
                                 output int lo, output int hi);
        v_mid = sat(v + dz(a_raw) - (v >>> 4));
        p_new = p + v_mid;
        lo    = (p_new < 0) ? 1 : 0;
        hi    = (p_new > lim) ? 1 : 0;
        if (lo != 0) p_new = 0;
        else if (hi != 0) p_new = lim;
        v_new = v_mid;
        if (lo != 0 || hi != 0) begin
`ifdef BALL_BOUNCE_EN
            v_new = -(v_mid - (v_mid >>> 2));
            if (v_new > -16 && v_new < 16) v_new = 0;
`else
            v_new = 0;
`endif
        end
    endfunction

    // Model: accepted tick at edge 0; accel read at +1, velocity visible at +2, result at +4.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_busy = 0; m_age = 0; m_lx = 0; m_ly = 0;
            m_vx = 0; m_vy = 0; m_px = XC * 16; m_py = YC * 16; m_wall = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (bus.recenter) begin
                m_busy = 0; m_vx = 0; m_vy = 0; m_px = XC * 16; m_py = YC * 16;
            end else if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    axis(m_lx, m_vx, m_px, X_LIM, r_vx_mid, r_px, r_vx, xl, xh);
                    axis(m_ly, m_vy, m_py, Y_LIM, r_vy_mid, r_py, r_vy, yl, yh);
                    r_wall = yl * 8 + yh * 4 + xh * 2 + xl;
                end else if (m_age == 2) begin
                    m_vx = r_vx_mid; m_vy = r_vy_mid;
                end else if (m_age == 4) begin
                    m_vx = r_vx; m_vy = r_vy; m_px = r_px; m_py = r_py;
                    m_wall = r_wall; m_done = 1; m_busy = 0;
                end
            end else if (m_cnt == TICK - 1 && !bus.hold) begin
                m_busy = 1; m_age = 0;
            end
            if (bus.accel_valid) begin
                m_lx = int'(bus.accel_x_in);
                m_ly = int'(bus.accel_y_in);
            end
            m_cnt = (m_cnt + 1) % TICK;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("pos_x", int'(bus.pos_x_out), m_px / 16);
            check("pos_y", int'(bus.pos_y_out), m_py / 16);
            check("vel_x", int'(bus.vel_x_out), m_vx);
            check("vel_y", int'(bus.vel_y_out), m_vy);
            check("update_done", int'(bus.update_done), int'(m_done));
            check("wall_hit", int'(bus.wall_hit), m_wall);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.update_done) begin
                got = 1;
                break;
            end
        end
        if (!got) check(name, 0, 1);
    endtask

    task automatic wait_model_age(input int age, input string name);
        bit got;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_busy && m_age == age) begin
                got = 1;
                break;
            end
        end
        if (!got) check(name, 0, 1);
    endtask

    task automatic pulse_valid(input int x, input int y);
        bus.accel_x_in  = 8'(x);
        bus.accel_y_in  = 8'(y);
        bus.accel_valid = 1'b1;
        @(negedge clk);
        bus.accel_valid = 1'b0;
    endtask

    task automatic pulse_recenter();
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
    endtask

    initial begin
        int first;
        int dones;
        bit hit;

        bus.accel_x_in = '0; bus.accel_y_in = '0; bus.accel_valid = 1'b0;
        bus.hold = 1'b0; bus.recenter = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pos_x", int'(bus.pos_x_out), 319);
        check("rst_pos_y", int'(bus.pos_y_out), 239);
        check("rst_vel_x", int'(bus.vel_x_out), 0);
        check("rst_wall", int'(bus.wall_hit), 0);
        check("rst_done", int'(bus.update_done), 0);

        // Strong +X tilt from reset: first update latency and first two steps.
        bus.accel_x_in = 8'sd64; bus.accel_valid = 1'b1; reset = 1'b1;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.accel_valid = 1'b0;
            if (bus.update_done) begin
                first = k;
                break;
            end
        end
        check("first_done_cycle", first, 20);
        check("upd1_vel_x", int'(bus.vel_x_out), 64);
        check("upd1_pos_x", int'(bus.pos_x_out), 323);
        wait_done("upd2_timeout");
        check("upd2_vel_x", int'(bus.vel_x_out), 124);
        check("upd2_pos_x", int'(bus.pos_x_out), 330);

        // Run into the right wall.
        hit = 0;
        for (int u = 0; u < 40 && !hit; u++) begin
            wait_done("t3_timeout");
            check("t3_no_wrap", (int'(bus.pos_x_out) >= 319) ? 1 : 0, 1);
            if (bus.wall_hit[1]) hit = 1;
        end
        check("t3_hit_right", int'(hit), 1);
        check("t3_pos_x", int'(bus.pos_x_out), 639);
`ifdef BALL_BOUNCE_EN
        check("t3_vel_reflected", (int'(bus.vel_x_out) < 0) ? 1 : 0, 1);
`else
        check("t3_vel_stopped", int'(bus.vel_x_out), 0);
`endif

        // Full -Y tilt into the top wall.
        pulse_valid(0, -128);
        pulse_recenter();
        check("t4_recenter_x", int'(bus.pos_x_out), 319);
        hit = 0;
        for (int u = 0; u < 40 && !hit; u++) begin
            wait_done("t4_timeout");
            check("t4_no_wrap", (int'(bus.pos_y_out) <= 239) ? 1 : 0, 1);
            check("t4_pos_x", int'(bus.pos_x_out), 319);
            if (bus.wall_hit[3]) hit = 1;
        end
        check("t4_hit_top", int'(hit), 1);
        check("t4_pos_y", int'(bus.pos_y_out), 0);
`ifdef BALL_BOUNCE_EN
        check("t4_vel_reflected", (int'(bus.vel_y_out) > 0) ? 1 : 0, 1);
`else
        check("t4_vel_stopped", int'(bus.vel_y_out), 0);
`endif

        // Tilts inside the dead-zone (x=+3, y=-4 at the boundary) leave the ball at rest.
        pulse_valid(3, -4);
        pulse_recenter();
        wait_done("t2_sync_timeout");
        dones = 0;
        for (int k = 0; k < 20 * TICK; k++) begin
            @(negedge clk);
            if (bus.update_done) dones++;
        end
        check("t2_done_count", dones, 20);
        check("t2_pos_x", int'(bus.pos_x_out), 319);
        check("t2_pos_y", int'(bus.pos_y_out), 239);
        check("t2_vel_x", int'(bus.vel_x_out), 0);
        check("t2_vel_y", int'(bus.vel_y_out), 0);

        // Hold for 10 tick periods, then resume.
        bus.hold = 1'b1;
        pulse_valid(50, 0);
        dones = 0;
        for (int k = 0; k < 10 * TICK; k++) begin
            @(negedge clk);
            if (bus.update_done) dones++;
        end
        check("t5_hold_dones", dones, 0);
        check("t5_hold_pos_x", int'(bus.pos_x_out), 319);
        check("t5_hold_vel_x", int'(bus.vel_x_out), 0);
        bus.hold = 1'b0;
        wait_done("t5_resume_timeout");
        check("t5_resume_vel_x", int'(bus.vel_x_out), 50);
        check("t5_resume_pos_x", int'(bus.pos_x_out), 322);

        // Recenter while the update is in its position step.
        wait_model_age(2, "t6_pos_timeout");
        pulse_recenter();
        check("t6_pos_x", int'(bus.pos_x_out), 319);
        check("t6_pos_y", int'(bus.pos_y_out), 239);
        check("t6_vel_x", int'(bus.vel_x_out), 0);
        check("t6_vel_y", int'(bus.vel_y_out), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.update_done) dones++;
        end
        check("t6_aborted_done", dones, 0);

        // New sample arriving in the SAMPLE cycle only takes effect on the next update.
        pulse_valid(0, 0);
        wait_model_age(0, "t6b_sample_timeout");
        pulse_valid(100, 0);
        wait_done("t6b_upd1_timeout");
        check("t6b_old_vel_x", int'(bus.vel_x_out), 0);
        check("t6b_old_pos_x", int'(bus.pos_x_out), 319);
        wait_done("t6b_upd2_timeout");
        check("t6b_new_vel_x", int'(bus.vel_x_out), 100);
        check("t6b_new_pos_x", int'(bus.pos_x_out), 325);

        // Asynchronous reset in the middle of a cycle.
        #3 reset = 1'b0;
        #1;
        check("t1_pos_x", int'(bus.pos_x_out), 319);
        check("t1_pos_y", int'(bus.pos_y_out), 239);
        check("t1_vel_x", int'(bus.vel_x_out), 0);
        check("t1_vel_y", int'(bus.vel_y_out), 0);
        check("t1_wall", int'(bus.wall_hit), 0);
        check("t1_done", int'(bus.update_done), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t1_after_pos_x", int'(bus.pos_x_out), 319);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
